// File: rtl/periph_interco_pkg.sv
// rtl/periph_interco_pkg.sv - shared types and helpers for the peripheral interconnect
package periph_interco_pkg;

  localparam int RESP_DATA_WIDTH = 32;

  typedef struct packed {
    logic [RESP_DATA_WIDTH-1:0] rdata;
    logic                       opc;
  } resp_t;

  // Out-of-range slave indexes fold onto the last peripheral port.
  function automatic int clamp_idx(input int idx, input int n_slave);
    return (idx > n_slave - 1) ? n_slave - 1 : idx;
  endfunction

endpackage

// File: rtl/resp_idx_fifo.sv
// rtl/resp_idx_fifo.sv - slave-index FIFO with wrap-at-DEPTH pointers and occupancy counter
module resp_idx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Explicit compare-and-reset so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/response_tracker_pe.sv
// rtl/response_tracker_pe.sv - in-order response return path per master; RESP_ERR_EN adds sticky err_o
module response_tracker_pe
  import periph_interco_pkg::*;
#(
  parameter int N_SLAVE         = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LOG_SLAVE       = $clog2(N_SLAVE)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_fire_i,
  input  logic [LOG_SLAVE-1:0]                  req_slave_i,
  output logic                                  full_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  input  logic [N_SLAVE-1:0]                    slave_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0]         slave_r_rdata_i,
  input  logic [N_SLAVE-1:0]                    slave_r_opc_i,
  output logic                                  r_valid_o,
  output logic [DATA_WIDTH-1:0]                 r_rdata_o,
  output logic                                  r_opc_o
`ifdef RESP_ERR_EN
  ,
  output logic                                  err_o
`endif
);

  logic [LOG_SLAVE-1:0]  push_idx;
  logic [LOG_SLAVE-1:0]  head_idx;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rdata_arr [N_SLAVE];
  resp_t                 resp_d, resp_q;
  logic                  valid_d, valid_q;

  assign push_idx = LOG_SLAVE'(clamp_idx(int'(req_slave_i), N_SLAVE));

  resp_idx_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LOG_SLAVE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_fire_i),
    .data_i  (push_idx),
    .pop_i   (pop),
    .head_o  (head_idx),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (outstanding_o)
  );

  for (genvar s = 0; s < N_SLAVE; s++) begin : g_rdata
    assign rdata_arr[s] = slave_r_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the slave at the FIFO head may complete; everything else is dropped.
  assign pop = !fifo_empty && slave_r_valid_i[head_idx];

  // DATA_WIDTH is expected not to exceed RESP_DATA_WIDTH of the shared response type.
  always_comb begin
    valid_d = pop;
    resp_d  = resp_q;
    if (pop) begin
      resp_d.rdata = RESP_DATA_WIDTH'(rdata_arr[head_idx]);
      resp_d.opc   = slave_r_opc_i[head_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      resp_q  <= '0;
    end else begin
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

  assign full_o    = fifo_full;
  assign r_valid_o = valid_q;
  assign r_rdata_o = resp_q.rdata[DATA_WIDTH-1:0];
  assign r_opc_o   = resp_q.opc;

`ifdef RESP_ERR_EN
  logic [N_SLAVE-1:0] head_mask;
  logic               err_event;
  logic               err_d, err_q;

  always_comb begin
    head_mask           = '0;
    head_mask[head_idx] = 1'b1;
    err_event = (req_fire_i && fifo_full) ||
                (fifo_empty ? (|slave_r_valid_i) : (|(slave_r_valid_i & ~head_mask)));
    err_d     = err_q | err_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_response_tracker_pe.sv
// tb/tb_response_tracker_pe.sv - scoreboard bench for response_tracker_pe (two configurations)
module tb_response_tracker_pe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 16 slaves, depth 4
  logic          fire_a;
  logic [3:0]    slv_a;
  logic [15:0]   rv_a;
  logic [511:0]  rdata_a;
  logic [15:0]   opc_a;
  logic          full_a;
  logic [2:0]    outst_a;
  logic          rvalid_a;
  logic [31:0]   rrdata_a;
  logic          ropc_a;

  // Instance B: 5 slaves, depth 3
  logic          fire_b;
  logic [2:0]    slv_b;
  logic [4:0]    rv_b;
  logic [159:0]  rdata_b;
  logic [4:0]    opc_b;
  logic          full_b;
  logic [1:0]    outst_b;
  logic          rvalid_b;
  logic [31:0]   rrdata_b;
  logic          ropc_b;

`ifdef RESP_ERR_EN
  logic err_a, err_b;
`endif

  response_tracker_pe #(.N_SLAVE(16), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut_a (
    .clk(clk), .rst(rst), .req_fire_i(fire_a), .req_slave_i(slv_a),
    .full_o(full_a), .outstanding_o(outst_a),
    .slave_r_valid_i(rv_a), .slave_r_rdata_i(rdata_a), .slave_r_opc_i(opc_a),
    .r_valid_o(rvalid_a), .r_rdata_o(rrdata_a), .r_opc_o(ropc_a)
`ifdef RESP_ERR_EN
    , .err_o(err_a)
`endif
  );

  response_tracker_pe #(.N_SLAVE(5), .DATA_WIDTH(32), .MAX_OUTSTANDING(3)) dut_b (
    .clk(clk), .rst(rst), .req_fire_i(fire_b), .req_slave_i(slv_b),
    .full_o(full_b), .outstanding_o(outst_b),
    .slave_r_valid_i(rv_b), .slave_r_rdata_i(rdata_b), .slave_r_opc_i(opc_b),
    .r_valid_o(rvalid_b), .r_rdata_o(rrdata_b), .r_opc_o(ropc_b)
`ifdef RESP_ERR_EN
    , .err_o(err_b)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_a(input logic f, input logic [3:0] s, input logic [15:0] rv,
                       input logic [31:0] d, input logic o);
    fire_a  = f;
    slv_a   = s;
    rv_a    = rv;
    rdata_a = {16{d}};
    opc_a   = {16{o}};
    @(posedge clk);
    #1;
    fire_a = 1'b0;
    rv_a   = '0;
  endtask

  task automatic cyc_b(input logic f, input logic [2:0] s, input logic [4:0] rv,
                       input logic [31:0] d, input logic o);
    fire_b  = f;
    slv_b   = s;
    rv_b    = rv;
    rdata_b = {5{d}};
    opc_b   = {5{o}};
    @(posedge clk);
    #1;
    fire_b = 1'b0;
    rv_b   = '0;
  endtask

  // Scoreboard: every r_valid_o must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid_a) begin
      n_tests++;
      assert (q_a.size() > 0) else begin
        n_fail++;
        $error("FAIL a_unexpected_valid: observed r_valid_o=1 expected 0");
      end
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_resp", {31'd0, rrdata_a, ropc_a}, {31'd0, e.d, e.o});
      end
    end
    if (rvalid_b) begin
      n_tests++;
      assert (q_b.size() > 0) else begin
        n_fail++;
        $error("FAIL b_unexpected_valid: observed r_valid_o=1 expected 0");
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_resp", {31'd0, rrdata_b, ropc_b}, {31'd0, e.d, e.o});
      end
    end
  end

  initial begin
    rst = 1'b1;
    fire_a = 1'b0; slv_a = '0; rv_a = '0; rdata_a = '0; opc_a = '0;
    fire_b = 1'b0; slv_b = '0; rv_b = '0; rdata_b = '0; opc_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rdata_a", rrdata_a, 0);
    chk("rst_opc_a", ropc_a, 0);
    chk("rst_full_a", full_a, 0);
    chk("rst_outst_a", outst_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_outst_b", outst_b, 0);
`ifdef RESP_ERR_EN
    chk("rst_err_a", err_a, 0);
`endif

    // Single round trip to slave 3
    cyc_a(1'b1, 4'd3, 16'h0000, 32'h0, 1'b0);
    chk("t1_outst_fire", outst_a, 1);
    chk("t1_rvalid_early", rvalid_a, 0);
    q_a.push_back({32'hDEADBEEF, 1'b0});
    cyc_a(1'b0, 4'd0, 16'h0008, 32'hDEADBEEF, 1'b0);
    chk("t1_rvalid", rvalid_a, 1);
    chk("t1_rdata", rrdata_a, 32'hDEADBEEF);
    chk("t1_outst_pop", outst_a, 0);
    cyc_a(1'b0, 4'd0, 16'h0000, 32'h0, 1'b0);
    chk("t1_rvalid_pulse", rvalid_a, 0);
    chk("t1_rdata_hold", rrdata_a, 32'hDEADBEEF);
`ifdef RESP_ERR_EN
    chk("t1_err_clean", err_a, 0);
`endif

    // In-order: fires 2,5,2; stray slave-5 pulse first is dropped
    cyc_a(1'b1, 4'd2, 16'h0000, 32'h0, 1'b0);
    cyc_a(1'b1, 4'd5, 16'h0000, 32'h0, 1'b0);
    cyc_a(1'b1, 4'd2, 16'h0000, 32'h0, 1'b0);
    chk("t2_outst3", outst_a, 3);
    cyc_a(1'b0, 4'd0, 16'h0020, 32'h1111, 1'b1);
    chk("t2_stray_ignored", rvalid_a, 0);
    chk("t2_outst_still3", outst_a, 3);
`ifdef RESP_ERR_EN
    chk("t2_err_set", err_a, 1);
`endif
    q_a.push_back({32'h2222, 1'b0});
    cyc_a(1'b0, 4'd0, 16'h0004, 32'h2222, 1'b0);
    q_a.push_back({32'h3333, 1'b1});
    cyc_a(1'b0, 4'd0, 16'h0020, 32'h3333, 1'b1);
    q_a.push_back({32'h4444, 1'b0});
    cyc_a(1'b0, 4'd0, 16'h0004, 32'h4444, 1'b0);
    chk("t2_outst_drained", outst_a, 0);
    cyc_a(1'b0, 4'd0, 16'h0000, 32'h0, 1'b0);

    // Full at depth 3: 4th fire dropped while the head pops
    cyc_b(1'b1, 3'd0, 5'b00000, 32'h0, 1'b0);
    cyc_b(1'b1, 3'd1, 5'b00000, 32'h0, 1'b0);
    cyc_b(1'b1, 3'd2, 5'b00000, 32'h0, 1'b0);
    chk("t3_full", full_b, 1);
    chk("t3_outst3", outst_b, 3);
    q_b.push_back({32'hA0, 1'b1});
    cyc_b(1'b1, 3'd3, 5'b00001, 32'hA0, 1'b1);
    chk("t3_outst_after", outst_b, 2);
    chk("t3_full_clear", full_b, 0);
    chk("t3_rvalid", rvalid_b, 1);
    chk("t3_opc", ropc_b, 1);
`ifdef RESP_ERR_EN
    chk("t3_err_set", err_b, 1);
`endif
    q_b.push_back({32'hA1, 1'b0});
    cyc_b(1'b0, 3'd0, 5'b00010, 32'hA1, 1'b0);
    q_b.push_back({32'hA2, 1'b0});
    cyc_b(1'b0, 3'd0, 5'b00100, 32'hA2, 1'b0);
    chk("t3_outst_drained", outst_b, 0);
    cyc_b(1'b0, 3'd0, 5'b01000, 32'hA3, 1'b0);
    chk("t3_dropped_not_tracked", rvalid_b, 0);

    // Clamp: index 7 on a 5-slave port tracks slave 4
    cyc_b(1'b1, 3'd7, 5'b00000, 32'h0, 1'b0);
    chk("t4_outst", outst_b, 1);
    cyc_b(1'b0, 3'd0, 5'b01000, 32'hC3, 1'b0);
    chk("t4_slave3_ignored", rvalid_b, 0);
    chk("t4_outst_kept", outst_b, 1);
    q_b.push_back({32'hC4, 1'b1});
    cyc_b(1'b0, 3'd0, 5'b10000, 32'hC4, 1'b1);
    chk("t4_slave4_rvalid", rvalid_b, 1);
    chk("t4_outst_empty", outst_b, 0);

    // Wrap-around with push and pop every cycle
    cyc_b(1'b1, 3'd0, 5'b00000, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      q_b.push_back({32'(256 + i), i[0]});
      cyc_b(i < 9, 3'((i + 1) % 5), 5'(1 << (i % 5)), 32'(256 + i), i[0]);
      chk("t6_outst", outst_b, (i < 9) ? 1 : 0);
      chk("t6_rvalid", rvalid_b, 1);
    end

    // Asynchronous reset with entries outstanding
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 4'(i), 16'h0000, 32'h0, 1'b0);
    chk("t5_full", full_a, 1);
    chk("t5_outst4", outst_a, 4);
    cyc_a(1'b0, 4'd0, 16'h0001, 32'h5555, 1'b1);
    chk("t5_pre_rvalid", rvalid_a, 1);
    chk("t5_pre_outst", outst_a, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_rvalid", rvalid_a, 0);
    chk("t5_rst_rdata", rrdata_a, 0);
    chk("t5_rst_opc", ropc_a, 0);
    chk("t5_rst_full", full_a, 0);
    chk("t5_rst_outst", outst_a, 0);
`ifdef RESP_ERR_EN
    chk("t5_rst_err", err_a, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cyc_a(1'b0, 4'd0, 16'h0002, 32'h6661, 1'b0);
    chk("t5_stale1", rvalid_a, 0);
    cyc_a(1'b0, 4'd0, 16'h0004, 32'h6662, 1'b0);
    chk("t5_stale2", rvalid_a, 0);
    cyc_a(1'b0, 4'd0, 16'h0008, 32'h6663, 1'b0);
    chk("t5_stale3", rvalid_a, 0);
    chk("t5_outst_after", outst_a, 0);

    cyc_a(1'b0, 4'd0, 16'h0000, 32'h0, 1'b0);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
